conv_reuse3_sequencer: RTL and testbench

- Control sequencer for the reuse-3 stride-2 3x3 convolution datapath (three row MAC lanes, one kernel column per cycle).
- Walks filters, output rows and output columns.
- Issues line-buffer read addresses, per-column weight select, accumulator clear/enable and filter index to the MAC lanes.
- Tags each finished window with an output address and honours downstream backpressure.

---
 rtl/conv_reuse3_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_reuse3_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_reuse3_sequencer.sv
// Control sequencer for the reuse-3 stride-2 3x3 conv datapath.
// Walks filter/oy/ox/col, issues reads, drives MAC lanes, tags results.
module conv_reuse3_sequencer #(
  parameter int IMG_W    = 18,
  parameter int IMG_H    = 18,
  parameter int STRIDE   = 2,
  parameter int NUM_FILT = 8,
  parameter int ADDR_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mac_en,
  output logic              mac_clear,
  output logic [1:0]        weight_col,
  output logic [3:0]        index,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int OW = (IMG_W - 3) / STRIDE + 1;
  localparam int OH = (IMG_H - 3) / STRIDE + 1;

  if ((IMG_W * IMG_H - 1) >= (2 ** ADDR_W) ||
      (NUM_FILT * OW * OH - 1) >= (2 ** ADDR_W) ||
      NUM_FILT > 16) begin : g_bad_params
    $error("conv_reuse3_sequencer: ADDR_W or NUM_FILT out of range");
  end

  localparam logic [ADDR_W-1:0] OW_A  = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] OH_A  = ADDR_W'(OH);
  localparam logic [ADDR_W-1:0] ST_A  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] IW_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WPF_A = ADDR_W'(OW * OH);
  localparam logic [3:0]        NF_L  = 4'(NUM_FILT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        col;
  logic [ADDR_W-1:0] ox;
  logic [ADDR_W-1:0] oy;
  logic [3:0]        fi;

  logic              v1;
  logic              clr1;
  logic [1:0]        col1;
  logic [3:0]        idx1;
  logic [ADDR_W-1:0] oa1;

  logic              stall;
  logic              last;
  logic [ADDR_W-1:0] win_addr;

  assign stall    = out_valid && !out_ready;
  assign last     = (col == 2'd2) && (ox == OW_A - 1'b1) &&
                    (oy == OH_A - 1'b1) && (fi == NF_L);
  assign rd_en    = (state == S_RUN) && !stall;
  assign rd_addr  = ST_A * oy * IW_A + ST_A * ox + ADDR_W'(col);
  assign win_addr = ADDR_W'(fi) * WPF_A + oy * OW_A + ox;

  assign mac_en     = v1 && !stall;
  assign mac_clear  = mac_en && clr1;
  assign weight_col = col1;
  assign index      = idx1;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (rd_en && last) state_nx = S_DRAIN;
      S_DRAIN: if (!v1 && out_valid && out_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Window walk: col fastest, then ox, oy, filter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      ox  <= '0;
      oy  <= '0;
      fi  <= '0;
    end else if (state == S_IDLE && start) begin
      col <= '0;
      ox  <= '0;
      oy  <= '0;
      fi  <= '0;
    end else if (rd_en) begin
      if (col == 2'd2) begin
        col <= '0;
        if (ox == OW_A - 1'b1) begin
          ox <= '0;
          if (oy == OH_A - 1'b1) begin
            oy <= '0;
            fi <= (fi == NF_L) ? 4'd0 : fi + 4'd1;
          end else begin
            oy <= oy + 1'b1;
          end
        end else begin
          ox <= ox + 1'b1;
        end
      end else begin
        col <= col + 2'd1;
      end
    end
  end

  // Read -> MAC -> result pipeline; frozen while a result is refused.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      clr1      <= 1'b0;
      col1      <= '0;
      idx1      <= '0;
      oa1       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else if (!stall) begin
      v1 <= rd_en;
      if (rd_en) begin
        col1 <= col;
        clr1 <= (col == 2'd0);
        idx1 <= fi;
        oa1  <= win_addr;
      end
      out_valid <= v1 && (col1 == 2'd2);
      if (v1 && (col1 == 2'd2)) out_addr <= oa1;
    end
  end

endmodule

// File: tb/tb_conv_reuse3_sequencer.sv
// Bench for conv_reuse3_sequencer: loop-order model, per-cycle compare,
// directed backpressure, restart and mid-pass reset scenarios.
module tb_conv_reuse3_sequencer;

  localparam int IMG_W    = 18;
  localparam int IMG_H    = 18;
  localparam int STRIDE   = 2;
  localparam int NUM_FILT = 8;
  localparam int ADDR_W   = 10;
  localparam int OW       = (IMG_W - 3) / STRIDE + 1;
  localparam int OH       = (IMG_H - 3) / STRIDE + 1;
  localparam int NW       = NUM_FILT * OW * OH;
  localparam int NR       = NW * 3;

  logic              clock;
  logic              reset;
  logic              start;
  logic              out_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              mac_en;
  logic              mac_clear;
  logic [1:0]        weight_col;
  logic [3:0]        index;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  conv_reuse3_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .STRIDE(STRIDE),
    .NUM_FILT(NUM_FILT), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .mac_en(mac_en), .mac_clear(mac_clear),
    .weight_col(weight_col), .index(index),
    .out_valid(out_valid), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ri, mi, oi, last_acc;
  int first_rd_cyc, first_ov_cyc, done_cnt, done_cyc;
  bit prev_stall;
  int p_oaddr, p_rd, p_idx;
  int rd_log[NR];
  int midx_log[NR];
  bit mclr_log[NR];
  int mac_cyc[8];
  int acc_cyc[NW];
  int idx_at_acc[NW];

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ri = 0;
    mi = 0;
    oi = 0;
    last_acc = -1;
    prev_stall = 0;
  endtask

  // Read n walks filter, oy, ox, col in that nesting.
  function automatic int exp_rd_addr(input int n);
    int w, c, x, y;
    w = n / 3;
    c = n % 3;
    x = w % OW;
    y = (w / OW) % OH;
    return STRIDE * y * IMG_W + STRIDE * x + c;
  endfunction

  function automatic int exp_idx(input int n);
    return (n / 3) / (OW * OH);
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      if (prev_stall)
        chk(out_valid && int'(out_addr) == p_oaddr &&
            int'(rd_addr) == p_rd && int'(index) == p_idx,
            "stall_hold", int'(out_addr), p_oaddr);
      if (out_valid && !out_ready)
        chk(!rd_en && !mac_en, "stall_quiet",
            int'({rd_en, mac_en}), 0);
      if (rd_en) begin
        if (ri == 0) first_rd_cyc = cyc;
        chk(busy, "busy_run", int'(busy), 1);
        if (ri < NR) begin
          rd_log[ri] = int'(rd_addr);
          chk(int'(rd_addr) == exp_rd_addr(ri), "rd_addr",
              int'(rd_addr), exp_rd_addr(ri));
        end else begin
          chk(1'b0, "rd_extra", ri, NR);
        end
        ri++;
      end
      if (mac_en) begin
        if (mi < 8) mac_cyc[mi] = cyc;
        if (mi < NR) begin
          mclr_log[mi] = mac_clear;
          midx_log[mi] = int'(index);
          chk(int'(weight_col) == mi % 3 &&
              mac_clear == (mi % 3 == 0) &&
              int'(index) == exp_idx(mi), "mac_ctrl",
              int'({index, mac_clear, weight_col}),
              (exp_idx(mi) << 3) | ((mi % 3 == 0) << 2) | (mi % 3));
        end else begin
          chk(1'b0, "mac_extra", mi, NR);
        end
        mi++;
      end
      if (out_valid && !prev_stall) begin
        if (oi == 0) first_ov_cyc = cyc;
        else chk(cyc - last_acc == 3, "ov_gap", cyc - last_acc, 3);
      end
      if (out_valid && out_ready) begin
        chk(int'(out_addr) == oi, "out_addr", int'(out_addr), oi);
        if (oi < NW) begin
          acc_cyc[oi] = cyc;
          idx_at_acc[oi] = int'(index);
        end
        oi++;
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk(oi == NW, "done_early", oi, NW);
      end
      prev_stall = out_valid && !out_ready;
      p_oaddr = int'(out_addr);
      p_rd = int'(rd_addr);
      p_idx = int'(index);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      step();
      t++;
    end
    chk(t < 3000, name, t, 3000);
  endtask

  task automatic zero_outputs(input string name);
    chk(!rd_en && rd_addr == '0 && !mac_en && !mac_clear &&
        weight_col == '0 && index == '0 && !out_valid &&
        out_addr == '0 && !busy && !done, name,
        int'({rd_en, mac_en, out_valid, busy, done}), 0);
  endtask

  int t;
  int exp6[6] = '{0, 1, 2, 2, 3, 4};
  int expw[6] = '{14, 15, 16, 36, 37, 38};

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    done_cnt = 0;
    done_cyc = 0;
    first_rd_cyc = 0;
    first_ov_cyc = 0;
    model_reset();
    repeat (3) step();
    zero_outputs("reset_state");
    reset = 1'b1;
    step();
    zero_outputs("idle_state");

    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (!(out_valid && out_addr == 10'd10) && t < 200) begin
      step();
      t++;
    end
    chk(t < 200, "wait_oa10", t, 200);
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("pass1_timeout");
    chk(!busy, "busy_fall", int'(busy), 0);
    repeat (3) step();

    for (int i = 0; i < 6; i++)
      chk(rd_log[i] == exp6[i], "first_reads", rd_log[i], exp6[i]);
    chk(mac_cyc[0] - first_rd_cyc == 1 && mclr_log[0],
        "clear_c1", mac_cyc[0] - first_rd_cyc, 1);
    chk(mac_cyc[3] - first_rd_cyc == 4 && mclr_log[3],
        "clear_c4", mac_cyc[3] - first_rd_cyc, 4);
    chk(!mclr_log[1], "clear_c2", int'(mclr_log[1]), 0);
    chk(first_ov_cyc - first_rd_cyc == 4, "first_ov",
        first_ov_cyc - first_rd_cyc, 4);
    for (int i = 0; i < 6; i++)
      chk(rd_log[21 + i] == expw[i], "row_wrap", rd_log[21 + i], expw[i]);
    chk(rd_log[192] == 0 && midx_log[192] == 1 && mclr_log[192],
        "filt_wrap_rd", midx_log[192], 1);
    chk(midx_log[191] == 0, "filt_prev", midx_log[191], 0);
    chk(idx_at_acc[64] == 1, "idx_at_64", idx_at_acc[64], 1);
    chk(acc_cyc[10] - acc_cyc[9] == 8, "stall_len",
        acc_cyc[10] - acc_cyc[9], 8);
    chk(acc_cyc[11] - acc_cyc[10] == 3, "after_stall",
        acc_cyc[11] - acc_cyc[10], 3);
    chk(ri == NR, "total_reads", ri, NR);
    chk(oi == NW, "total_results", oi, NW);
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    chk(done_cyc - acc_cyc[NW-1] == 1, "done_timing",
        done_cyc - acc_cyc[NW-1], 1);

    model_reset();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (!(out_valid && out_addr == 10'd200) && t < 2000) begin
      step();
      t++;
    end
    chk(t < 2000, "wait_oa200", t, 2000);
    reset = 1'b0;
    #1;
    zero_outputs("async_abort");
    repeat (4) step();
    chk(done_cnt == 0, "no_done_abort", done_cnt, 0);
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while ((ri == 0 || mi == 0) && t < 10) begin
      step();
      t++;
    end
    chk(ri > 0 && rd_log[0] == 0, "restart_addr", rd_log[0], 0);
    chk(mi > 0 && midx_log[0] == 0, "restart_idx", midx_log[0], 0);
    wait_done("pass3_timeout");
    chk(oi == NW && done_cnt == 1, "pass3_done", oi, NW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
